// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the CPU memory-stage port and the DMA/loader port
// for the single-ported DataMemory: grant, fixed-latency access, one-cycle ack.
module dmem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_MW,
  output logic        m_MR,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        owner,
  output logic        busy
);

  localparam int CW = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t         state_q;
  logic           last_q;
  logic           gnt_q;
  logic           we_q;
  logic           mw_q;
  logic           mr_q;
  logic           c_ack_q;
  logic           d_ack_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    c_rdata_q;
  logic [31:0]    d_rdata_q;

  logic           any_req;
  logic           pick_d;
  logic           sel_we;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_wdata;

  // On a tie the port that was not served last wins; last_q=1 means DMA.
  assign any_req   = c_req | d_req;
  assign pick_d    = d_req & (~c_req | ~last_q);
  assign sel_we    = pick_d ? d_we    : c_we;
  assign sel_addr  = pick_d ? d_addr  : c_addr;
  assign sel_wdata = pick_d ? d_wdata : c_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      mw_q      <= 1'b0;
      mr_q      <= 1'b0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q <= S_ACCESS;
            gnt_q   <= pick_d;
            last_q  <= pick_d;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= CW'(LAT - 1);
            mw_q    <= sel_we;
            mr_q    <= ~sel_we;
          end
        end
        S_ACCESS: begin
          // Writes take a single strobe cycle regardless of LAT.
          if (we_q || (cnt_q == '0)) begin
            state_q <= S_ACK;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            if (gnt_q) d_ack_q <= 1'b1;
            else       c_ack_q <= 1'b1;
            if (!we_q) begin
              if (gnt_q) d_rdata_q <= m_rdata;
              else       c_rdata_q <= m_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_MW    = mw_q;
  assign m_MR    = mr_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign c_ack   = c_ack_q;
  assign d_ack   = d_ack_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign c_stall = c_req & ~c_ack_q;
  assign owner   = gnt_q;
  assign busy    = (state_q == S_ACCESS) || (state_q == S_ACK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a vector table on a LAT=1 instance plus hand-written
// sequences (tie/alternation, late address change, mid-access reset) on LAT=3.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LAT=1 instance signals
  logic        a_rst_n, a_c_req, a_c_we, a_d_req, a_d_we;
  logic [31:0] a_c_addr, a_c_wdata, a_d_addr, a_d_wdata;
  logic        a_c_ack, a_d_ack, a_c_stall, a_m_MW, a_m_MR, a_owner, a_busy;
  logic [31:0] a_c_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  // LAT=3 instance signals
  logic        b_rst_n, b_c_req, b_c_we, b_d_req, b_d_we;
  logic [31:0] b_c_addr, b_c_wdata, b_d_addr, b_d_wdata;
  logic        b_c_ack, b_d_ack, b_c_stall, b_m_MW, b_m_MR, b_owner, b_busy;
  logic [31:0] b_c_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

  dmem_arbiter #(.LAT(1)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
    .c_ack(a_c_ack), .c_rdata(a_c_rdata), .c_stall(a_c_stall),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .m_MW(a_m_MW), .m_MR(a_m_MR), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(a_m_rdata), .owner(a_owner), .busy(a_busy)
  );

  dmem_arbiter #(.LAT(3)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
    .c_ack(b_c_ack), .c_rdata(b_c_rdata), .c_stall(b_c_stall),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .m_MW(b_m_MW), .m_MR(b_m_MR), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata), .owner(b_owner), .busy(b_busy)
  );

  // Memory model: fixed contents unless a word has been written
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h10:  rom = 32'hCAFE0001;
      32'h20:  rom = 32'h12345678;
      32'h30:  rom = 32'h33333333;
      default: rom = a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  logic        mem_clr;
  logic [31:0] mem_a [64];
  logic [63:0] wv_a;
  logic [5:0]  a_idx;
  assign a_idx     = a_m_addr[7:2];
  assign a_m_rdata = wv_a[a_idx] ? mem_a[a_idx] : rom(a_m_addr);
  assign b_m_rdata = rom(b_m_addr);

  always @(posedge clk) begin
    if (mem_clr) wv_a <= '0;
    else if (a_m_MW) begin
      mem_a[a_idx] <= a_m_wdata;
      wv_a[a_idx]  <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic        mw, mr;
    logic [31:0] maddr, mwdata;
    logic        cack, dack, stall, busy, owner;
    logic [31:0] crd, drd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic [31:0] da,
    input logic mw, input logic mr, input logic [31:0] ma, input logic [31:0] md,
    input logic cak, input logic dak, input logic st, input logic by, input logic ow,
    input logic [31:0] crd, input logic [31:0] drd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = 1'b0; v.d_addr = da;
    v.mw = mw; v.mr = mr; v.maddr = ma; v.mwdata = md;
    v.cack = cak; v.dack = dak; v.stall = st; v.busy = by; v.owner = ow;
    v.crd = crd; v.drd = drd;
    return v;
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] RD = 32'h12345678;
  localparam logic [31:0] CF = 32'hCAFE0001;

  vec_t vt [21];
  int   exp_cyc [4] = '{4, 9, 14, 19};
  logic exp_who [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int   n_ack, mr_d, n_cack, got;

  task automatic chk_rst(input string t, input logic mw, input logic mr,
                         input logic [31:0] ma, input logic [31:0] md,
                         input logic ca, input logic da,
                         input logic [31:0] crd, input logic [31:0] drd,
                         input logic ow, input logic by);
    chk({t, "_mw"}, 32'(mw), 0);   chk({t, "_mr"}, 32'(mr), 0);
    chk({t, "_maddr"}, ma, 0);     chk({t, "_mwdata"}, md, 0);
    chk({t, "_cack"}, 32'(ca), 0); chk({t, "_dack"}, 32'(da), 0);
    chk({t, "_crd"}, crd, 0);      chk({t, "_drd"}, drd, 0);
    chk({t, "_owner"}, 32'(ow), 0); chk({t, "_busy"}, 32'(by), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cr cw ca      cd  dr da      mw mr ma      md  cak dak st by ow crd drd
    vt[0]  = mk(1, 1, 32'h10, DB, 0, 32'h0,  0, 0, 32'h0,  0,  0, 0, 1, 0, 0, 0,  0);
    vt[1]  = mk(1, 1, 32'h10, DB, 0, 32'h0,  1, 0, 32'h10, DB, 0, 0, 1, 1, 0, 0,  0);
    vt[2]  = mk(1, 1, 32'h10, DB, 0, 32'h0,  0, 0, 32'h10, DB, 1, 0, 0, 1, 0, 0,  0);
    vt[3]  = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 0, 32'h10, DB, 0, 0, 1, 0, 0, 0,  0);
    vt[4]  = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 1, 32'h10, 0,  0, 0, 1, 1, 0, 0,  0);
    vt[5]  = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 0, 32'h10, 0,  1, 0, 0, 1, 0, DB, 0);
    vt[6]  = mk(0, 0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h10, 0,  0, 0, 0, 0, 0, DB, 0);
    vt[7]  = mk(0, 0, 32'h0,  0,  1, 32'h10, 0, 0, 32'h10, 0,  0, 0, 0, 0, 0, DB, 0);
    vt[8]  = mk(0, 0, 32'h0,  0,  1, 32'h10, 0, 1, 32'h10, 0,  0, 0, 0, 1, 1, DB, 0);
    vt[9]  = mk(0, 0, 32'h0,  0,  1, 32'h10, 0, 0, 32'h10, 0,  0, 1, 0, 1, 1, DB, DB);
    vt[10] = mk(0, 0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h10, 0,  0, 0, 0, 0, 1, DB, DB);
    vt[11] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 0, 32'h10, 0,  0, 0, 1, 0, 1, DB, DB);
    vt[12] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 1, 32'h10, 0,  0, 0, 1, 1, 0, DB, DB);
    vt[13] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 0, 32'h10, 0,  1, 0, 0, 1, 0, DB, DB);
    vt[14] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 0, 32'h10, 0,  0, 0, 1, 0, 0, DB, DB);
    vt[15] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 1, 32'h20, 0,  0, 0, 1, 1, 1, DB, DB);
    vt[16] = mk(1, 0, 32'h10, 0,  1, 32'h20, 0, 0, 32'h20, 0,  0, 1, 1, 1, 1, DB, RD);
    vt[17] = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 0, 32'h20, 0,  0, 0, 1, 0, 1, DB, RD);
    vt[18] = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 1, 32'h10, 0,  0, 0, 1, 1, 0, DB, RD);
    vt[19] = mk(1, 0, 32'h10, 0,  0, 32'h0,  0, 0, 32'h10, 0,  1, 0, 0, 1, 0, DB, RD);
    vt[20] = mk(0, 0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h10, 0,  0, 0, 0, 0, 0, DB, RD);

    mem_clr = 1'b1;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_c_req = 0; a_c_we = 0; a_c_addr = 0; a_c_wdata = 0;
    a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
    b_c_req = 0; b_c_we = 0; b_c_addr = 0; b_c_wdata = 0;
    b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;

    // Reset values, and c_stall tracking c_req while in reset
    @(posedge clk); #1;
    chk_rst("rst_a", a_m_MW, a_m_MR, a_m_addr, a_m_wdata, a_c_ack, a_d_ack,
            a_c_rdata, a_d_rdata, a_owner, a_busy);
    chk_rst("rst_b", b_m_MW, b_m_MR, b_m_addr, b_m_wdata, b_c_ack, b_d_ack,
            b_c_rdata, b_d_rdata, b_owner, b_busy);
    chk("rst_stall_lo", 32'(a_c_stall), 0);
    a_c_req = 1; #1;
    chk("rst_stall_hi", 32'(a_c_stall), 1);
    a_c_req = 0;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    chk("rel_busy", 32'(a_busy), 0);
    chk("rel_owner", 32'(b_owner), 0);

    // Vector table on the LAT=1 instance
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      a_c_req = vt[i].c_req; a_c_we = vt[i].c_we;
      a_c_addr = vt[i].c_addr; a_c_wdata = vt[i].c_wdata;
      a_d_req = vt[i].d_req; a_d_we = vt[i].d_we; a_d_addr = vt[i].d_addr;
      @(negedge clk);
      chk($sformatf("v%0d_mw", i),     32'(a_m_MW),    32'(vt[i].mw));
      chk($sformatf("v%0d_mr", i),     32'(a_m_MR),    32'(vt[i].mr));
      chk($sformatf("v%0d_maddr", i),  a_m_addr,       vt[i].maddr);
      chk($sformatf("v%0d_mwdata", i), a_m_wdata,      vt[i].mwdata);
      chk($sformatf("v%0d_cack", i),   32'(a_c_ack),   32'(vt[i].cack));
      chk($sformatf("v%0d_dack", i),   32'(a_d_ack),   32'(vt[i].dack));
      chk($sformatf("v%0d_stall", i),  32'(a_c_stall), 32'(vt[i].stall));
      chk($sformatf("v%0d_busy", i),   32'(a_busy),    32'(vt[i].busy));
      chk($sformatf("v%0d_owner", i),  32'(a_owner),   32'(vt[i].owner));
      chk($sformatf("v%0d_crd", i),    a_c_rdata,      vt[i].crd);
      chk($sformatf("v%0d_drd", i),    a_d_rdata,      vt[i].drd);
    end

    // LAT=3: simultaneous reads, both kept high -> C, D, C, D five cycles apart
    @(posedge clk); #1;
    b_c_req = 1; b_c_we = 0; b_c_addr = 32'h10;
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h20;
    n_ack = 0; mr_d = 0;
    for (int cyc = 0; cyc < 40 && n_ack < 4; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (b_m_MR && b_owner && n_ack == 1) mr_d++;
      if (b_c_ack || b_d_ack) begin
        chk($sformatf("tie%0d_cycle", n_ack), 32'(cyc), 32'(exp_cyc[n_ack]));
        chk($sformatf("tie%0d_dma", n_ack), 32'(b_d_ack), 32'(exp_who[n_ack]));
        chk($sformatf("tie%0d_cpu", n_ack), 32'(b_c_ack), 32'(!exp_who[n_ack]));
        if (n_ack == 1) begin
          chk("lat3_drd", b_d_rdata, RD);
          chk("lat3_crd_kept", b_c_rdata, CF);
        end
        n_ack++;
      end
    end
    chk("tie_acks", 32'(n_ack), 4);
    chk("lat3_mr_cycles", 32'(mr_d), 3);
    @(posedge clk); #1;
    b_c_req = 0; b_d_req = 0;

    // Address change after grant is ignored
    @(posedge clk); #1;
    b_c_req = 1; b_c_addr = 32'h10;
    @(posedge clk); #1;
    b_c_addr = 32'h30;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("chg%0d_maddr", k), b_m_addr, 32'h10);
      chk($sformatf("chg%0d_mr", k), 32'(b_m_MR), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("chg_cack", 32'(b_c_ack), 1);
    chk("chg_crd", b_c_rdata, CF);
    @(posedge clk); #1;
    b_c_req = 0; b_c_addr = 0;

    // Reset in the middle of a LAT=3 read, DMA request pending
    @(posedge clk); #1;
    b_c_req = 1; b_c_addr = 32'h10;
    @(posedge clk); #1;
    b_d_req = 1; b_d_addr = 32'h20;
    @(posedge clk); #1;
    chk("mrst_pre_mr", 32'(b_m_MR), 1);
    #2;
    b_rst_n = 0;
    #1;
    chk("mrst_mr", 32'(b_m_MR), 0);
    chk("mrst_busy", 32'(b_busy), 0);
    chk("mrst_cack", 32'(b_c_ack), 0);
    chk("mrst_drd", b_d_rdata, 0);
    b_c_req = 0;
    @(posedge clk); #1;
    chk("mrst_hold_cack", 32'(b_c_ack), 0);
    @(posedge clk); #2;
    b_rst_n = 1;
    got = 0; n_cack = 0;
    for (int k = 0; k < 12 && got == 0; k++) begin
      @(negedge clk);
      if (b_c_ack) n_cack++;
      if (b_d_ack) begin
        got = 1;
        chk("mrst_dack_cycle", 32'(k), 4);
        chk("mrst_drd_new", b_d_rdata, RD);
        chk("mrst_owner", 32'(b_owner), 1);
      end
    end
    chk("mrst_dack_seen", 32'(got), 1);
    chk("mrst_no_cack", 32'(n_cack), 0);
    @(posedge clk); #1;
    b_d_req = 0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
